// File: rtl/ps2_host_tx_if.sv
// Command-side and pad-side signals of the PS/2 host transmitter.
// The slave modport is the transmitter; the master modport is its surroundings.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] dbg_state;

  // Handshake: a command is taken on the rising clk edge where tx_valid and
  // tx_ready are both 1; tx_valid seen while tx_ready is 0 is dropped, never queued.
  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error, dbg_state
  );

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error, dbg_state
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10-bit shift
// clocked by the device, acknowledge check, and a device-silence timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000,
  parameter int FILTER_LEN  = 8
) (
  input logic          clk,
  input logic          rst,
  ps2_host_tx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAITREL = 3'd5;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [2:0]    r_state;
  logic [IW-1:0] r_inh_cnt;
  logic [19:0]   r_to_cnt;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic          r_dat_oe;

  logic w_fall, w_active, w_timeout, w_accept, w_inh_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_filt     <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_fall     = r_filt & ~r_clk_s2 & (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_active   = (r_state == S_REQ) | (r_state == S_SHIFT) |
                      (r_state == S_ACK) | (r_state == S_WAITREL);
  assign w_timeout  = w_active & (r_to_cnt == 20'(TIMEOUT_CYC));
  assign w_accept   = bus.tx_valid & (r_state == S_IDLE);
  assign w_inh_last = (r_state == S_INHIBIT) & (r_inh_cnt == IW'(INHIBIT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_frame   <= '0;
      r_dat_oe  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Frame bits in wire order after the start bit: data LSB first, odd parity, stop.
            r_frame   <= {1'b1, ~^bus.tx_data, bus.tx_data};
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_dat_oe  <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (w_inh_last) begin
            r_to_cnt <= '0;
            r_state  <= S_REQ;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        S_REQ, S_SHIFT, S_ACK, S_WAITREL: begin
          if (w_timeout) begin
            r_dat_oe <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_to_cnt <= w_fall ? 20'd0 : r_to_cnt + 20'd1;
            if (r_state == S_REQ || r_state == S_SHIFT) begin
              if (w_fall) begin
                r_dat_oe  <= ~r_frame[r_bit_cnt];
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_state   <= (r_bit_cnt == 4'd9) ? S_ACK : S_SHIFT;
              end
            end else if (r_state == S_ACK) begin
              if (w_fall) r_state <= r_dat_s2 ? S_IDLE : S_WAITREL;
            end else if (r_filt & r_dat_s2) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_ready   = (r_state == S_IDLE);
  assign bus.busy       = ~bus.tx_ready;
  assign bus.ps2_clk_oe = (r_state == S_INHIBIT);
  assign bus.ps2_dat_oe = w_inh_last |
                          (~w_timeout & ((r_state == S_REQ) |
                          (((r_state == S_SHIFT) | (r_state == S_ACK)) & r_dat_oe)));
  assign bus.done       = (r_state == S_WAITREL) & r_filt & r_dat_s2 & ~w_timeout;
  assign bus.error      = w_timeout | ((r_state == S_ACK) & w_fall & r_dat_s2);
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 keyboard model clocks the frame out and a
// frame model built from the protocol rules predicts what the device samples.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int FL   = 8;
  localparam int HALF = 40;

  logic clk;
  logic rst;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    int         exp_done;
    int         exp_err;
    bit         exp_par;
  } vec_t;
  vec_t vecs[6];

  ps2_host_tx_if bus();
  assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
      if (bus.error === 1'b1) err_cnt <= err_cnt + 1;
      if (bus.done === 1'b1 && bus.error === 1'b1) both_cnt <= both_cnt + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // reference model: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // driver tasks
  task automatic send_cmd(input logic [7:0] d);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check("send_ready_wait", 0, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) check("idle_wait", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic dev_xfer(input bit ack, input bit glitch, input int pulses,
                          output logic [10:0] frame, output int inh, output int both,
                          output bit ok);
    int n = 0;
    frame = '0; inh = 0; both = 0; ok = 1'b1;
    while (bus.ps2_clk_oe !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin ok = 1'b0; return; end
    while (bus.ps2_clk_oe === 1'b1 && inh < 20 * INH) begin
      inh++;
      if (bus.ps2_dat_oe === 1'b1) both++;
      @(negedge clk);
    end
    for (int i = 0; i < pulses; i++) begin
      if (glitch && i == 4) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      frame[i] = bus.ps2_dat_in;
      if (i == 10 && ack) begin
        dev_dat_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    if (pulses == 11) begin
      repeat (HALF) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [10:0] fr;
    int inh, both;
    bit ok;
    exp_q.push_back(model_frame(v.data));
    fork
      send_cmd(v.data);
      dev_xfer(v.ack, v.glitch, 11, fr, inh, both, ok);
    join
    wait_idle();
    check({name, "_dev_ok"}, 32'(ok), 1);
    check({name, "_frame"}, 32'(fr), 32'(exp_q.pop_front()));
    check({name, "_parity"}, 32'(fr[9]), 32'(v.exp_par));
    check({name, "_inhibit_len"}, inh, INH);
    check({name, "_dat_in_inhibit"}, both, 1);
    check({name, "_done"}, done_cnt - d0, v.exp_done);
    check({name, "_error"}, err_cnt - e0, v.exp_err);
    check({name, "_oe_released"}, {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    check({name, "_ready"}, 32'(bus.tx_ready), 1);
  endtask

  initial begin
    logic [10:0] fr, mf;
    int inh, both, n, t0, t1, d0, e0, seen;
    bit ok;
    vec_t rv;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 1, 0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 0, 1, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1, 0, 1'b1};
    vecs[5] = '{8'h7F, 1'b1, 1'b0, 1, 0, 1'b0};

    rst = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    check("rst_pulses", {bus.done, bus.error}, 0);
    check("rst_state", 32'(bus.dbg_state), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.data     = 8'($urandom_range(0, 255));
      rv.ack      = 1'($urandom_range(0, 1));
      rv.glitch   = 1'($urandom_range(0, 1));
      rv.exp_done = rv.ack ? 1 : 0;
      rv.exp_err  = rv.ack ? 0 : 1;
      mf          = model_frame(rv.data);
      rv.exp_par  = mf[9];
      run_vec($sformatf("rnd%0d", i), rv);
    end

    // silent device: timeout measured from the first request-to-send cycle
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_cmd(8'h55);
      begin
        n = 0;
        while (bus.ps2_clk_oe !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (bus.ps2_clk_oe === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (bus.error !== 1'b1 && n < 3 * TO) begin @(negedge clk); n++; end
        t1 = cyc;
        check("timeout_cycles", t1 - t0, TO);
        check("timeout_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        check("timeout_no_done", 32'(bus.done), 0);
      end
    join
    wait_idle();
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 0);

    // tx_valid while busy is dropped and tx_data is not re-latched
    d0 = done_cnt;
    exp_q.push_back(model_frame(8'h3C));
    fork
      send_cmd(8'h3C);
      dev_xfer(1'b1, 1'b0, 11, fr, inh, both, ok);
      begin
        repeat (300) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    wait_idle();
    check("busy_frame", 32'(fr), 32'(exp_q.pop_front()));
    check("busy_done", done_cnt - d0, 1);
    seen = 0;
    repeat (200) begin @(negedge clk); if (bus.ps2_clk_oe === 1'b1) seen++; end
    check("busy_not_queued", seen, 0);

    // reset after the 4th edge, then a command in the first cycle after release
    fork
      send_cmd(8'h96);
      dev_xfer(1'b1, 1'b0, 4, fr, inh, both, ok);
    join
    d0 = done_cnt; e0 = err_cnt;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    check("midrst_ready", {bus.tx_ready, bus.busy}, 2);
    check("midrst_state", 32'(bus.dbg_state), 0);
    repeat (3) @(negedge clk);
    exp_q.push_back(model_frame(8'hF4));
    fork
      dev_xfer(1'b1, 1'b0, 11, fr, inh, both, ok);
      begin
        bus.tx_data  = 8'hF4;
        bus.tx_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("accept_after_rst", 32'(bus.ps2_clk_oe), 1);
        bus.tx_valid = 1'b0;
      end
    join
    wait_idle();
    check("midrst_frame", 32'(fr), 32'(exp_q.pop_front()));
    check("midrst_inhibit_len", inh, INH);
    check("midrst_done", done_cnt - d0, 1);
    check("midrst_error", err_cnt - e0, 0);

    check("done_error_same_cycle", both_cnt, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
